// File: rtl/crypto_req_pkg.sv
// Shared definitions for crypto request routing: default widths, opcodes,
// request layout and the instruction-width helper.
package crypto_req_pkg;

   localparam int ADDRW_DEF   = 8;
   localparam int OPCODEW_DEF = 2;

   localparam logic [OPCODEW_DEF-1:0] OP_AES = 2'd0;
   localparam logic [OPCODEW_DEF-1:0] OP_SHA = 2'd1;

   typedef struct packed {
      logic [OPCODEW_DEF-1:0] opcode;
      logic [ADDRW_DEF-1:0]   key_addr;
      logic [ADDRW_DEF-1:0]   text_addr;
   } req_t;

   function automatic int instr_width(input int addrw, input int opcodew);
      return 2 * addrw + opcodew;
   endfunction

endpackage

// File: rtl/req_fifo.sv
// Single-channel first-word-fall-through FIFO with occupancy count and
// synchronous clear. Pushes while full and pops while empty are ignored.
module req_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   output logic                       full,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTRW-1:0]  wptr;
   logic [PTRW-1:0]  rptr;
   logic [CNTW-1:0]  cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CNTW'(DEPTH));
   assign valid   = (cnt != '0);
   assign do_push = push & ~full & ~clr;
   assign do_pop  = pop & valid & ~clr;
   assign dout    = mem[rptr];
   assign count   = cnt;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/req_dispatch_queue.sv
// Steers {opcode, key_addr, text_addr} requests by opcode into independent
// per-destination FWFT FIFOs; out-of-range opcodes are accepted and dropped.
module req_dispatch_queue
   import crypto_req_pkg::*;
#(
   parameter int ADDRW   = ADDRW_DEF,
   parameter int OPCODEW = OPCODEW_DEF,
   parameter int QLENGTH = 16,
   parameter int NDEST   = 2,
   localparam int INSTRW = instr_width(ADDRW, OPCODEW),
   localparam int CNTW   = $clog2(QLENGTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic [OPCODEW-1:0]      opcode,
   input  logic [ADDRW-1:0]        key_addr,
   input  logic [ADDRW-1:0]        text_addr,
   output logic [NDEST-1:0]        valid_out,
   input  logic [NDEST-1:0]        ready_in,
   output logic [NDEST*INSTRW-1:0] instr,
   output logic [NDEST*CNTW-1:0]   count,
   output logic                    illegal_op
);

   logic [INSTRW-1:0] word;
   logic [NDEST-1:0]  full;
   logic [NDEST-1:0]  push;
   logic              legal;
   logic              full_sel;

   assign word = {opcode, key_addr, text_addr};

   // Decode only ever matches an existing destination, so legality and the
   // selected full flag come out of the same loop.
   always_comb begin
      legal    = 1'b0;
      full_sel = 1'b0;
      push     = '0;
      for (int d = 0; d < NDEST; d++) begin
         if (int'(opcode) == d) begin
            legal    = 1'b1;
            full_sel = full[d];
            push[d]  = valid_in & ~full[d];
         end
      end
   end

   assign ready_out = legal ? ~full_sel : 1'b1;

   always_ff @(posedge clk) begin
      if (rst || flush) illegal_op <= 1'b0;
      else              illegal_op <= valid_in & ~legal;
   end

   for (genvar g = 0; g < NDEST; g++) begin : g_dest
      req_fifo #(
         .WIDTH(INSTRW),
         .DEPTH(QLENGTH)
      ) u_fifo (
         .clk  (clk),
         .rst  (rst),
         .clr  (flush),
         .push (push[g]),
         .din  (word),
         .full (full[g]),
         .pop  (ready_in[g]),
         .dout (instr[g*INSTRW +: INSTRW]),
         .valid(valid_out[g]),
         .count(count[g*CNTW +: CNTW])
      );
   end

endmodule

// File: tb/tb_req_dispatch_queue.sv
// Scoreboard bench for req_dispatch_queue: directed pushes feed per-destination
// expectation queues, a negedge monitor checks every handshaked output word.
module tb_req_dispatch_queue;
   import crypto_req_pkg::*;

   localparam int INSTRW = 18;
   localparam int CNTW   = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic               flush;
   logic               valid_in;
   logic               ready_out;
   logic [1:0]         opcode;
   logic [7:0]         key_addr;
   logic [7:0]         text_addr;
   logic [1:0]         valid_out;
   logic [1:0]         ready_in;
   logic [2*INSTRW-1:0] instr;
   logic [2*CNTW-1:0]  count;
   logic               illegal_op;

   int total = 0;
   int bad   = 0;

   logic [INSTRW-1:0] q0[$];
   logic [INSTRW-1:0] q1[$];

   always #5 clk = ~clk;

   req_dispatch_queue dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .opcode    (opcode),
      .key_addr  (key_addr),
      .text_addr (text_addr),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .instr     (instr),
      .count     (count),
      .illegal_op(illegal_op)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [INSTRW-1:0] mk(input int op, input int k, input int t);
      req_t r;
      r.opcode    = op[1:0];
      r.key_addr  = k[7:0];
      r.text_addr = t[7:0];
      return r;
   endfunction

   // Presents one request for a single cycle; acc is the hand-expected ready_out.
   task automatic push_req(input int op, input int k, input int t, input bit acc);
      valid_in  = 1'b1;
      opcode    = op[1:0];
      key_addr  = k[7:0];
      text_addr = t[7:0];
      @(negedge clk);
      chk("ready_out", 32'(ready_out), 32'(acc));
      if (acc && !flush && !rst) begin
         if (op == 0) q0.push_back(mk(op, k, t));
         else if (op == 1) q1.push_back(mk(op, k, t));
      end
      tick();
      valid_in = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      ready_in = 2'b11;
      while (valid_out != 2'b00 && n < 64) begin
         tick();
         n++;
      end
      chk("drain_done", 32'(valid_out), 32'd0);
      ready_in = 2'b00;
      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);
   endtask

   // Monitor: every word that leaves on a handshake must match the scoreboard.
   always @(negedge clk) begin
      if (!rst && !flush) begin
         if (valid_out[0] && ready_in[0]) begin
            if (q0.size() == 0) chk("dest0_unexpected", 32'(instr[INSTRW-1:0]), 32'hFFFF_FFFF);
            else chk("dest0_data", 32'(instr[INSTRW-1:0]), 32'(q0.pop_front()));
         end
         if (valid_out[1] && ready_in[1]) begin
            if (q1.size() == 0) chk("dest1_unexpected", 32'(instr[2*INSTRW-1:INSTRW]), 32'hFFFF_FFFF);
            else chk("dest1_data", 32'(instr[2*INSTRW-1:INSTRW]), 32'(q1.pop_front()));
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; valid_in = 1'b0; opcode = '0;
      key_addr = '0; text_addr = '0; ready_in = '0;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_illegal", 32'(illegal_op), 32'd0);
      chk("rst_ready", 32'(ready_out), 32'd1);
      tick();

      // Single SHA request with 1-cycle latency and a pop.
      push_req(OP_SHA, 8'h12, 8'h34, 1'b1);
      @(negedge clk);
      chk("t1_valid_out", 32'(valid_out), 32'h2);
      chk("t1_instr1", 32'(instr[2*INSTRW-1:INSTRW]), 32'h11234);
      chk("t1_count1", 32'(count[2*CNTW-1:CNTW]), 32'd1);
      tick();
      ready_in = 2'b10;
      tick();
      ready_in = 2'b00;
      @(negedge clk);
      chk("t1_count1_pop", 32'(count[2*CNTW-1:CNTW]), 32'd0);
      chk("t1_valid_pop", 32'(valid_out), 32'd0);
      tick();

      // Fill AES to capacity, confirm SHA still flows, then wrap.
      for (int i = 0; i < 16; i++) push_req(OP_AES, i, i + 8'h40, 1'b1);
      @(negedge clk);
      chk("t2_count0_full", 32'(count[CNTW-1:0]), 32'd16);
      push_req(OP_AES, 8'hEE, 8'hEE, 1'b0);
      push_req(OP_SHA, 8'h77, 8'h88, 1'b1);
      @(negedge clk);
      chk("t2_count1", 32'(count[2*CNTW-1:CNTW]), 32'd1);
      chk("t2_count0_held", 32'(count[CNTW-1:0]), 32'd16);
      tick();
      ready_in = 2'b01;
      tick();
      ready_in = 2'b00;
      push_req(OP_AES, 8'h10, 8'h50, 1'b1);
      @(negedge clk);
      chk("t2_count0_wrap", 32'(count[CNTW-1:0]), 32'd16);
      tick();
      drain();

      // Steady push+pop at occupancy 5.
      for (int i = 0; i < 5; i++) push_req(OP_AES, 8'h80 + i, 8'hC0 + i, 1'b1);
      ready_in = 2'b01;
      for (int i = 0; i < 20; i++) begin
         valid_in  = 1'b1;
         opcode    = OP_AES;
         key_addr  = 8'(8'hA0 + i);
         text_addr = 8'(8'h20 + i);
         @(negedge clk);
         chk("t3_count0", 32'(count[CNTW-1:0]), 32'd5);
         chk("t3_ready", 32'(ready_out), 32'd1);
         q0.push_back(mk(0, 8'hA0 + i, 8'h20 + i));
         tick();
      end
      valid_in = 1'b0;
      drain();

      // Illegal opcode: accepted, dropped, one-cycle pulse.
      push_req(2, 8'h55, 8'h66, 1'b1);
      @(negedge clk);
      chk("t4_illegal_pulse", 32'(illegal_op), 32'd1);
      chk("t4_counts", 32'(count), 32'd0);
      tick();
      @(negedge clk);
      chk("t4_illegal_clear", 32'(illegal_op), 32'd0);
      tick();

      // Flush with a concurrent push and pops.
      for (int i = 0; i < 7; i++) push_req(OP_AES, i, 8'h90 + i, 1'b1);
      for (int i = 0; i < 3; i++) push_req(OP_SHA, i, 8'hB0 + i, 1'b1);
      flush = 1'b1;
      ready_in = 2'b11;
      push_req(OP_AES, 8'hDD, 8'hDD, 1'b1);
      flush = 1'b0;
      ready_in = 2'b00;
      q0.delete();
      q1.delete();
      @(negedge clk);
      chk("t5_counts", 32'(count), 32'd0);
      chk("t5_valid_out", 32'(valid_out), 32'd0);
      tick();

      // Reset mid-stream, then first push latency.
      for (int i = 0; i < 4; i++) push_req(OP_AES, i, 8'h10 + i, 1'b1);
      @(negedge clk);
      chk("t6_count0", 32'(count[CNTW-1:0]), 32'd4);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q0.delete();
      @(negedge clk);
      chk("t6_rst_counts", 32'(count), 32'd0);
      chk("t6_rst_valid", 32'(valid_out), 32'd0);
      tick();
      push_req(OP_SHA, 8'hAB, 8'hCD, 1'b1);
      @(negedge clk);
      chk("t6_latency", 32'(valid_out), 32'h2);
      tick();
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
